// File: rtl/vector_serializer.sv
// Column-vector serializer: captures M elements on load, streams them over valid/ready.
// Optional upper-bound clipping of each element is enabled by defining VSER_CLIP_EN.
`timescale 1ns/1ps
module vector_serializer #(
    parameter int M     = 5,
    parameter int SHAMT = 12,
    parameter int DW    = 32,
    localparam int IW   = $clog2(M) + 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          load,
    input  logic [0:M-1][0:0][DW-1:0]     in,
    output logic signed [DW-1:0]          out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic [IW-1:0]                 out_index,
    output logic                          busy,
    output logic                          done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(M - 1);

    // Reject shapes the index counter or the clip bound cannot represent.
    if (M < 1 || M > 1024 || SHAMT < 0 || SHAMT >= DW) begin : g_param_check
        $error("vector_serializer: illegal M/SHAMT/DW combination");
    end

    state_t                   state_q, state_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [M-1:0][DW-1:0]     buf_q, buf_d;
    logic signed [DW-1:0]     cur_elem;
    logic                     beat;

    assign out_valid = (state_q == S_SEND);
    assign busy      = (state_q == S_SEND) || (state_q == S_DONE);
    assign done      = (state_q == S_DONE);
    assign out_last  = out_valid && (idx_q == LAST_IDX);
    assign out_index = idx_q;
    assign beat      = out_valid && out_ready && enable;

    // Select the buffered element addressed by the current index.
    always_comb begin
        cur_elem = '0;
        for (int i = 0; i < M; i++) begin
            if (idx_q == IW'(i)) begin
                cur_elem = buf_q[i];
            end
        end
    end

`ifdef VSER_CLIP_EN
    localparam logic signed [DW-1:0] CLIP_MAX = DW'((64'sd1 <<< SHAMT) - 64'sd1);

    // Saturate large positive values; negatives pass unchanged.
    always_comb begin
        out_data = cur_elem;
        if (cur_elem > CLIP_MAX) begin
            out_data = CLIP_MAX;
        end
    end
`else
    // Stream the buffered element unmodified.
    always_comb begin
        out_data = cur_elem;
    end
`endif

    // Next-state logic: capture in IDLE, advance on beats in SEND, one-cycle DONE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        unique case (state_q)
            S_IDLE: begin
                if (load && enable) begin
                    for (int i = 0; i < M; i++) begin
                        buf_d[i] = in[i][0];
                    end
                    idx_d   = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (beat) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, index and buffer registers; reset discards any vector in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
        end
    end

endmodule

// File: tb/tb_vector_serializer.sv
// Scoreboard bench for vector_serializer: random traffic, backpressure, stalls, reset.
// Expected beats are queued at load time and checked by an independent monitor.
`timescale 1ns/1ps
module tb_vector_serializer;

    localparam int M  = 5;
    localparam int DW = 32;
    localparam int IW = $clog2(M) + 1;

    logic                      clk;
    logic                      rst_n;
    logic                      enable;
    logic                      load;
    logic [0:M-1][0:0][DW-1:0] in_s;
    logic signed [DW-1:0]      out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic                      out_last;
    logic [IW-1:0]             out_index;
    logic                      busy;
    logic                      done;

    vector_serializer #(.M(M), .SHAMT(12), .DW(DW)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .enable    (enable),
        .load      (load),
        .in        (in_s),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_index (out_index),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int data;
        int idx;
        bit last;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   done_pend  = 0;
    bit   prev_stall = 0;
    int   prev_data, prev_idx, prev_last;
    int   vec[M];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference element value after the optional saturation stage.
    function automatic int model_elem(input int v);
`ifdef VSER_CLIP_EN
        return (v > 4095) ? 4095 : v;
`else
        return v;
`endif
    endfunction

    // Monitor: checks done pulses, stall stability and every accepted beat.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("done", int'(done), int'(done_pend));
            done_pend = 0;
            if (prev_stall) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_data", int'(out_data), prev_data);
                chk("hold_index", int'(out_index), prev_idx);
                chk("hold_last", int'(out_last), prev_last);
            end
            prev_stall = 0;
            if (out_valid && out_ready && enable) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_beat", int'(out_data), -1);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("data", int'(out_data), e.data);
                    chk("index", int'(out_index), e.idx);
                    chk("last", int'(out_last), int'(e.last));
                    if (e.last) done_pend = 1;
                end
            end else if (out_valid) begin
                prev_stall = 1;
                prev_data  = int'(out_data);
                prev_idx   = int'(out_index);
                prev_last  = int'(out_last);
            end
        end
    end

    function automatic int rand_val();
        case ($urandom_range(0, 3))
            0: return int'($urandom);
            1: return $urandom_range(4090, 4100);
            2: return -int'($urandom_range(1, 100));
            default: return 0;
        endcase
    endfunction

    // Issue a load from IDLE (caller is at posedge+1 with busy low) and queue the model.
    task automatic do_load(output time t0);
        exp_t e;
        chk("idle_before_load", int'(busy), 0);
        t0 = $time;
        load   = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < M; i++) begin
            in_s[i][0] = vec[i];
            e.data = model_elem(vec[i]);
            e.idx  = i;
            e.last = (i == M - 1);
            sbq.push_back(e);
        end
        @(posedge clk); #1;
        load = 1'b0;
        for (int i = 0; i < M; i++) in_s[i][0] = $urandom;
        chk("latency_valid", int'(out_valid), 1);
        chk("latency_index", int'(out_index), 0);
    endtask

    // Drive traffic until the serializer returns to IDLE.
    // mode 0 random, 1 full rate, 2 alternate ready, 3 load 9s mid-vector, 4 enable gap
    task automatic run_until_idle(input int mode);
        int k;
        k = 0;
        while (busy) begin
            case (mode)
                0: begin
                    out_ready = $urandom_range(0, 1);
                    enable    = ($urandom_range(0, 7) != 0);
                    load      = ($urandom_range(0, 3) == 0);
                    for (int i = 0; i < M; i++) in_s[i][0] = $urandom;
                end
                1: begin
                    out_ready = 1'b1; enable = 1'b1; load = 1'b0;
                end
                2: begin
                    out_ready = k[0]; enable = 1'b1; load = 1'b0;
                end
                3: begin
                    out_ready = 1'b1; enable = 1'b1;
                    load = (k == 1);
                    for (int i = 0; i < M; i++) in_s[i][0] = 9;
                end
                default: begin
                    out_ready = 1'b1; load = 1'b0;
                    enable = !(k >= 2 && k <= 4);
                end
            endcase
            @(posedge clk); #1;
            k++;
            if (k > 200) begin
                chk("idle_timeout", k, 0);
                return;
            end
        end
        load = 1'b0; enable = 1'b1; out_ready = 1'b1;
    endtask

    initial begin
        time t0;
        int  cyc;
        rst_n = 1'b0; enable = 1'b0; load = 1'b0; out_ready = 1'b0;
        in_s = '0;
        #12;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_index", int'(out_index), 0);
        chk("rst_data", int'(out_data), 0);
        chk("rst_last", int'(out_last), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        enable = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Load ignored while enable is low.
        vec = '{7, 7, 7, 7, 7};
        for (int i = 0; i < M; i++) in_s[i][0] = 7;
        load = 1'b1; enable = 1'b0;
        @(posedge clk); #1;
        chk("load_gated_busy", int'(busy), 0);
        load = 1'b0; enable = 1'b1;

        // Full-rate vector: M beats then done, M+2 cycle period.
        vec = '{1, 2, 3, 4, 5};
        do_load(t0);
        run_until_idle(1);
        chk("period", int'(($time - t0) / 10), M + 2);

        vec = '{1, 2, 3, 4, 5};
        do_load(t0);
        run_until_idle(2);

        vec = '{1, 2, 3, 4, 5};
        do_load(t0);
        run_until_idle(3);
        vec = '{11, 12, 13, 14, 15};
        do_load(t0);
        run_until_idle(1);

        vec = '{21, 22, 23, 24, 25};
        do_load(t0);
        run_until_idle(4);

        vec = '{5000, -7, 4095, 4096, 0};
        do_load(t0);
        run_until_idle(0);

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < M; i++) vec[i] = rand_val();
            do_load(t0);
            run_until_idle(0);
        end

        // Asynchronous reset in the middle of a vector.
        vec = '{31, 32, 33, 34, 35};
        do_load(t0);
        cyc = 0;
        while (out_index != 2 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("reach_index2", int'(out_index), 2);
        #2;
        rst_n = 1'b0;
        sbq.delete();
        done_pend  = 0;
        prev_stall = 0;
        #1;
        chk("async_valid", int'(out_valid), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_done", int'(done), 0);
        chk("async_index", int'(out_index), 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("post_rst_valid", int'(out_valid), 0);
            chk("post_rst_busy", int'(busy), 0);
        end

        vec = '{41, -42, 43, 44, 45};
        do_load(t0);
        run_until_idle(0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
